// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch stage (master) and imem (slave).
// One request outstanding at a time; ImemReq is held until a single-cycle ImemValid.
interface fetch_unit_if;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemValid,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemValid,
        output ImemRdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, hands it to decode.
// Optional macro FETCH_ALIGN_CHECK_EN turns a misaligned taken branch into a fetch fault.
module fetch_unit #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                Advance,
    input  logic                BranchTaken,
    input  logic [63:0]         BranchTarget,
    output logic [31:0]         Instr,
    output logic [63:0]         PC,
    output logic                InstrValid,
    output logic                Halted,
    output logic                FetchFault
);

    localparam int unsigned      CNT_W        = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [63:0]      branch_pc_c;
    logic [63:0]      next_pc_c;
    logic             misaligned_c;

    // Request is a pure function of state; address is always the current PC.
    assign imem.ImemReq  = (state == FETCH);
    assign imem.ImemAddr = PC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign branch_pc_c  = BranchTarget;
    assign misaligned_c = BranchTaken && (BranchTarget[1:0] != 2'b00);
`else
    assign branch_pc_c  = BranchTarget & ~64'd3;
    assign misaligned_c = 1'b0;
`endif

    assign next_pc_c = BranchTaken ? branch_pc_c : (PC + 64'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            PC         <= RESET_PC;
            Instr      <= 32'h0;
            InstrValid <= 1'b0;
            Halted     <= 1'b0;
            FetchFault <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Data arriving on the last allowed cycle still beats the timeout.
                    if (imem.ImemValid) begin
                        wait_cnt <= '0;
                        if (imem.ImemRdata != 32'h0) begin
                            Instr      <= imem.ImemRdata;
                            InstrValid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            Halted <= 1'b1;
                            state  <= HALT;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        FetchFault <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (Advance) begin
                        InstrValid <= 1'b0;
                        wait_cnt   <= '0;
                        PC         <= next_pc_c;
                        if (misaligned_c) begin
                            FetchFault <= 1'b1;
                            state      <= FAULT;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    // HALT and FAULT are terminal until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the sequential 64-bit RISC-V core, directly upstream of instruction decode.
- Owns the PC register and issues one instruction-memory read at a time over a req/valid handshake.
- Presents the fetched 32-bit instruction and its PC to decode, then waits for the core to retire it.
- On retire, redirects to the branch target or advances PC+4; detects halt (all-zero word) and memory timeout.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
IMEM_TIMEOUT, 255, cycles ImemReq may stay unanswered before fault (1..65535)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
Advance  in  1  one-cycle pulse: core has retired the current instruction
BranchTaken  in  1  qualified by Advance: redirect to BranchTarget
BranchTarget  in  64  branch destination (PC + ImmExt, computed downstream)
ImemReq  out  1  read request, held until ImemValid
ImemAddr  out  64  read address, equals PC while ImemReq=1
ImemValid  in  1  read data valid, single-cycle
ImemRdata  in  32  instruction word
Instr  out  32  instruction to decode
PC  out  64  address of Instr
InstrValid  out  1  Instr/PC valid for decode
Halted  out  1  sticky: all-zero instruction fetched
FetchFault  out  1  sticky: memory timeout (or misalignment, see option)

Behaviour:
- Reset (reset=0, async): state=FETCH, PC=RESET_PC, Instr=0, InstrValid=0, Halted=0, FetchFault=0, timeout counter=0. ImemReq is combinational from state, so ImemReq=1 in the first cycle after reset release.
- States: FETCH, HOLD, HALT, FAULT.
- FETCH:
  - ImemReq=1, ImemAddr=PC; counter increments each cycle without ImemValid.
  - ImemValid=1 with ImemRdata!=0: latch Instr, go to HOLD. InstrValid=1 from the next cycle.
  - ImemValid=1 with ImemRdata==0: go to HALT, Halted=1, InstrValid stays 0.
  - Counter reaches IMEM_TIMEOUT with no ImemValid: go to FAULT, FetchFault=1, ImemReq drops.
  - ImemValid in the same cycle the counter reaches IMEM_TIMEOUT: data wins, no fault.
- HOLD:
  - ImemReq=0; InstrValid=1; Instr and PC stable.
  - On Advance: PC <= BranchTaken ? BranchTarget : PC+4 (mod 2^64 wrap), InstrValid<=0, counter<=0, go to FETCH. New ImemReq/ImemAddr appear the cycle after Advance.
- HALT and FAULT: terminal until reset. ImemReq=0, InstrValid=0, PC holds the offending address.
- Ignored inputs: Advance outside HOLD; BranchTaken/BranchTarget without Advance; ImemValid outside FETCH.
- Latency:
  - ImemValid at cycle N gives InstrValid at N+1.
  - Minimum loop is 2 cycles per instruction (Advance, then a 0-wait memory response).
- Mid-operation reset: an outstanding request is abandoned. The instruction memory shares reset and must drop any in-flight response.
- Only one request outstanding at any time; ImemAddr never changes while ImemReq=1.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: on Advance with BranchTaken=1 and BranchTarget[1:0]!=0, load PC=BranchTarget, go to FAULT, FetchFault=1. No request is issued.
- Undefined: BranchTarget[1:0] is ignored (forced to 2'b00 when loaded into PC); no misalignment fault exists.
- Sequential PC+4 never misaligns in either build.

Test Plan:
- Reset with RESET_PC=0x1000, memory returns 0x00A00093 after 0 waits: ImemReq=1, ImemAddr=0x1000 in the first cycle after release. InstrValid=1, Instr=0x00A00093, PC=0x1000 one cycle after ImemValid.
- Advance with BranchTaken=0 at PC=0x1000: next cycle ImemAddr=0x1004, InstrValid=0. A 3-wait response gives InstrValid 4 cycles after the request.
- Advance with BranchTaken=1, BranchTarget=0x2000: ImemAddr=0x2000. A second Advance pulse during FETCH is ignored (PC stays 0x2000).
- Memory returns 0x00000000: Halted=1, InstrValid=0, ImemReq=0 permanently. reset=0 clears Halted and refetches from RESET_PC.
- IMEM_TIMEOUT=4, no ImemValid: FetchFault=1 after the 4th request cycle, ImemReq=0. A late ImemValid is ignored.
- FETCH_ALIGN_CHECK_EN defined, BranchTarget=0x2002 taken: FetchFault=1, PC=0x2002. Undefined build: ImemAddr=0x2000, no fault.
